// File: rtl/matrix_multiply_3x3_feeder.sv
// Feeds a 3x3 matrix-multiply core: passes sample vectors through with one cycle of
// latency and streams a snapshot of the 9-entry coefficient shadow bank on request.
module matrix_multiply_3x3_feeder #(
    parameter int COEF_W = 16,
    parameter int SMP_W  = 16
) (
    input  logic                          system1000,
    input  logic                          system1000_rst,
    input  logic                          cfg_we,
    input  logic [3:0]                    cfg_addr,
    input  logic [COEF_W-1:0]             cfg_data,
    input  logic                          cfg_commit,
    input  logic                          smp_valid,
    input  logic [SMP_W-1:0]              smp_x0,
    input  logic [SMP_W-1:0]              smp_x1,
    input  logic [SMP_W-1:0]              smp_x2,
    output logic [6+COEF_W+3*SMP_W-1:0]   arg,
    output logic                          busy,
    output logic                          load_done
);
    localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(1) << (COEF_W - 2);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic                pending_q, pending_d;
    logic                boot_q;
    logic                snap;
    logic                commit_req;

    logic [COEF_W-1:0]   shadow_q [9];
    logic [COEF_W-1:0]   shadow_d [9];
    logic [COEF_W-1:0]   xfer_q   [9];

    logic                sv_q, sv_d;
    logic                cw_q, cw_d;
    logic [3:0]          cidx_q, cidx_d;
    logic [COEF_W-1:0]   coef_q, coef_d;
    logic [3*SMP_W-1:0]  data_q, data_d;
    logic                done_q, done_d;

    // The first cycle out of reset acts as a commit so the core starts with identity.
    assign commit_req = cfg_commit | boot_q;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_bank
            // Snapshot takes shadow_d so a write in the commit cycle is captured.
            always_comb begin
                shadow_d[gi] = shadow_q[gi];
                if (cfg_we && cfg_addr == 4'(gi))
                    shadow_d[gi] = cfg_data;
            end

            always_ff @(posedge system1000) begin
                if (system1000_rst) begin
                    shadow_q[gi] <= (gi % 4 == 0) ? COEF_ONE : '0;
                    xfer_q[gi]   <= '0;
                end else begin
                    shadow_q[gi] <= shadow_d[gi];
                    if (snap)
                        xfer_q[gi] <= shadow_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            boot_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            boot_q    <= 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        snap      = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit_req) begin
                    state_d   = LOAD;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    snap      = 1'b1;
                end
            end
            LOAD: begin
                if (idx_q == 4'd8) begin
                    idx_d     = '0;
                    pending_d = 1'b0;
                    if (pending_q || commit_req)
                        snap = 1'b1;
                    else
                        state_d = IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                    if (commit_req)
                        pending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cw_d   = (state_q == LOAD);
        cidx_d = (state_q == LOAD) ? idx_q : 4'd0;
        coef_d = (state_q == LOAD) ? xfer_q[idx_q] : '0;
        sv_d   = smp_valid;
        data_d = smp_valid ? {smp_x2, smp_x1, smp_x0} : data_q;
        done_d = cw_q && (cidx_q == 4'd8);
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            sv_q   <= 1'b0;
            cw_q   <= 1'b0;
            cidx_q <= '0;
            coef_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            sv_q   <= sv_d;
            cw_q   <= cw_d;
            cidx_q <= cidx_d;
            coef_q <= coef_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end

    assign arg       = {sv_q, cw_q, cidx_q, coef_q, data_q};
    assign busy      = cw_q;
    assign load_done = done_q;
endmodule

// File: tb/tb_matrix_multiply_3x3_feeder.sv
// Directed bench: expected coefficient words are queued as loads are requested and
// checked by a negedge monitor as the feeder issues them.
module tb_matrix_multiply_3x3_feeder;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_commit;
    logic        smp_valid;
    logic [15:0] smp_x0, smp_x1, smp_x2;
    logic [69:0] arg;
    logic        busy;
    logic        load_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int run_len = 0;
    int last_run = 0;
    logic mon_en = 1'b0;

    logic [19:0] exp_q[$];
    logic [15:0] sh [9];

    matrix_multiply_3x3_feeder #(.COEF_W(16), .SMP_W(16)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_commit     (cfg_commit),
        .smp_valid      (smp_valid),
        .smp_x0         (smp_x0),
        .smp_x1         (smp_x1),
        .smp_x2         (smp_x2),
        .arg            (arg),
        .busy           (busy),
        .load_done      (load_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_identity();
        for (int i = 0; i < 9; i++) sh[i] = (i % 4 == 0) ? 16'h4000 : 16'h0000;
    endtask

    task automatic push_load(input int count);
        for (int i = 0; i < count; i++) exp_q.push_back({4'(i), sh[i]});
    endtask

    task automatic write_sh(input logic [3:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
        if (a <= 4'd8) sh[a] = d;
    endtask

    task automatic commit_pulse();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_queue_left", 96'(exp_q.size()), 96'd0);
        repeat (2) tick();
    endtask

    // Monitor: every issued coefficient must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy_vs_coefwrite", 96'(busy), 96'(arg[68]));
            if (arg[68]) begin
                run_len++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL coef_unexpected: observed idx %0d coef %h expected none", arg[67:64], arg[63:48]);
                end
                if (exp_q.size() != 0) chk("coef_word", 96'({arg[67:64], arg[63:48]}), 96'(exp_q.pop_front()));
            end else if (run_len != 0) begin
                last_run = run_len;
                run_len = 0;
            end
            if (load_done) done_cnt++;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        smp_valid = 1'b0; smp_x0 = '0; smp_x1 = '0; smp_x2 = '0;
        set_identity();
        repeat (3) tick();
        chk("reset_arg", 96'(arg), 96'd0);
        chk("reset_busy", 96'(busy), 96'd0);
        chk("reset_done", 96'(load_done), 96'd0);

        // Automatic identity load after reset release
        mon_en = 1'b1;
        push_load(9);
        rst = 1'b0;
        drain();
        chk("boot_done_cnt", 96'(done_cnt), 96'd1);
        chk("boot_run", 96'(last_run), 96'd9);
        chk("idle_busy", 96'(busy), 96'd0);
        chk("idle_coef_fields", 96'(arg[68:48]), 96'd0);

        // Sample path
        smp_valid = 1'b1; smp_x0 = 16'h0001; smp_x1 = 16'h8000; smp_x2 = 16'h7FFF;
        tick();
        chk("smp_valid_hi", 96'(arg[69]), 96'd1);
        chk("smp_data", 96'(arg[47:0]), 96'h7FFF_8000_0001);
        smp_valid = 1'b0; smp_x0 = 16'h5555; smp_x1 = 16'h5555; smp_x2 = 16'h5555;
        tick();
        chk("smp_valid_lo", 96'(arg[69]), 96'd0);
        chk("smp_hold", 96'(arg[47:0]), 96'h7FFF_8000_0001);
        smp_valid = 1'b1; smp_x0 = 16'hFFFF; smp_x1 = 16'h0000; smp_x2 = 16'h1234;
        tick();
        chk("smp_data2", 96'(arg[47:0]), 96'h1234_0000_FFFF);
        smp_valid = 1'b0;

        // Write during LOAD does not disturb the sequence in flight
        write_sh(4'd3, 16'h1234);
        push_load(9);
        commit_pulse();
        tick();
        smp_valid = 1'b1; smp_x0 = 16'h0042;
        write_sh(4'd3, 16'h5678);
        chk("smp_during_load", 96'({arg[69], arg[15:0]}), 96'h1_0042);
        smp_valid = 1'b0;
        drain();
        chk("snap_done_cnt", 96'(done_cnt), 96'd2);
        push_load(9);
        commit_pulse();
        drain();
        chk("shadow_retained_done", 96'(done_cnt), 96'd3);

        // Write and commit in the same cycle
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 16'h2222; sh[1] = 16'h2222;
        push_load(9);
        commit_pulse();
        cfg_we = 1'b0;
        drain();
        chk("same_cycle_done", 96'(done_cnt), 96'd4);

        // Out-of-range address is ignored
        cfg_we = 1'b1; cfg_addr = 4'd12; cfg_data = 16'hFFFF;
        push_load(9);
        commit_pulse();
        cfg_we = 1'b0;
        drain();
        chk("addr12_done", 96'(done_cnt), 96'd5);

        // Commits at index 5 and 8 collapse into one restart
        push_load(9);
        commit_pulse();
        repeat (5) tick();
        commit_pulse();
        write_sh(4'd7, 16'h0BAD);
        tick();
        push_load(9);
        commit_pulse();
        drain();
        chk("restart_done_cnt", 96'(done_cnt), 96'd7);
        chk("restart_run", 96'(last_run), 96'd18);

        // Commit only on the final index still restarts
        push_load(9);
        commit_pulse();
        repeat (8) tick();
        push_load(9);
        commit_pulse();
        drain();
        chk("last_idx_done_cnt", 96'(done_cnt), 96'd9);
        chk("last_idx_run", 96'(last_run), 96'd18);

        // Reset mid-LOAD aborts without load_done
        push_load(4);
        commit_pulse();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("abort_arg", 96'(arg), 96'd0);
        chk("abort_busy", 96'(busy), 96'd0);
        chk("abort_done", 96'(load_done), 96'd0);
        tick();
        set_identity();
        push_load(9);
        rst = 1'b0;
        drain();
        chk("abort_done_cnt", 96'(done_cnt), 96'd10);
        chk("abort_reload_run", 96'(last_run), 96'd9);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
